// File: rtl/isa_pkg.sv
// isa_pkg: shared IITB-RISC widths, pc register index and LM/SM sequencer state encoding
package isa_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int NREG = 8;
  localparam int REG_AW = 3;
  localparam logic [REG_AW-1:0] REG_PC = 3'd7;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_DONE = 2'd2} seq_state_e;
endpackage

// File: rtl/lsb_prienc.sv
// lsb_prienc: index of the lowest set bit of mask, valid when mask is nonzero
module lsb_prienc
  import isa_pkg::*;
(
  input  logic [NREG-1:0]   mask,
  output logic [REG_AW-1:0] idx,
  output logic              valid
);
  always_comb begin
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) idx = mask[i] ? REG_AW'(i) : idx;
  end
  assign valid = |mask;
endmodule

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: walks an LM/SM register list, one reg_bank/memory transfer per handshake
module lm_sm_sequencer
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREG-1:0]   reg_list,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic [REG_AW-1:0] rd_addr,
  output logic              reg_write,
  output logic [REG_AW-1:0] wr_add,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              done
);
  seq_state_e        state_q, state_d;
  logic [NREG-1:0]   mask_q, mask_d, lm_list;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              store_q, store_d, valid, xfer;
  logic [REG_AW-1:0] idx;
  lsb_prienc u_enc (.mask(mask_q), .idx(idx), .valid(valid));
  assign xfer = (state_q == S_XFER) && valid;
  assign lm_list = is_store ? reg_list : reg_list & ~(NREG'(1) << REG_PC);
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    addr_d = addr_q;
    store_d = store_q;
    if (state_q == S_IDLE && start) begin
      store_d = is_store;
      addr_d = base_addr;
      mask_d = lm_list;
      state_d = |lm_list ? S_XFER : S_DONE;
    end else if (xfer && mem_ready) begin
      mask_d = mask_q & (mask_q - 1'b1);
      addr_d = addr_q + 1'b1;
      state_d = |mask_d ? S_XFER : S_DONE;
    end else if (state_q != S_IDLE && !xfer) begin
      state_d = state_q == S_DONE ? S_IDLE : S_DONE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q <= '0;
      addr_q <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      addr_q <= addr_d;
      store_q <= store_d;
    end
  end
  assign mem_rd = xfer & ~store_q;
  assign mem_wr = xfer & store_q;
  assign mem_addr = xfer ? addr_q : '0;
  assign rd_addr = xfer ? idx : '0;
  assign mem_wr_data = mem_wr ? rd_data : '0;
  assign reg_write = mem_rd & mem_ready;
  assign wr_add = reg_write ? idx : '0;
  assign wr_data = reg_write ? mem_rd_data : '0;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: randomized LM/SM checks against a transfer-list reference model
module tb_lm_sm_sequencer;
  import isa_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_store = 1'b0, mem_ready = 1'b0;
  logic [15:0] base_addr = '0, mem_rd_data, rd_data, wr_data, mem_addr, mem_wr_data;
  logic [7:0] reg_list = '0;
  logic [2:0] rd_addr, wr_add;
  logic reg_write, mem_rd, mem_wr, busy, done;
  logic [15:0] mem [0:65535];
  logic [15:0] regs [0:7];
  int passed = 0, total = 0;
  typedef struct packed {logic wr; logic we; logic [2:0] r; logic [15:0] a; logic [15:0] d;} xact_t;
  lm_sm_sequencer dut (.clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .base_addr(base_addr),
    .reg_list(reg_list), .mem_ready(mem_ready), .mem_rd_data(mem_rd_data), .rd_data(rd_data),
    .rd_addr(rd_addr), .reg_write(reg_write), .wr_add(wr_add), .wr_data(wr_data), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data), .busy(busy), .done(done));
  always #5 clk = ~clk;
  assign mem_rd_data = mem[mem_addr];
  assign rd_data = regs[rd_addr];
  task automatic do_op(input logic st, input logic [15:0] base, input logic [7:0] list, input int pct, input bit noise);
    xact_t exp_q[$];
    xact_t got_q[$];
    logic [15:0] a = base;
    int cyc = 0, dones = 0;
    bit bad = 0;
    for (int i = 0; i < 8; i++)
      if (list[i] && (st || i != 7)) begin
        exp_q.push_back('{st, !st, 3'(i), a, st ? regs[i] : mem[a]});
        a++;
      end
    @(negedge clk);
    is_store = st; base_addr = base; reg_list = list; start = 1'b1; mem_ready = 1'b1;
    while (cyc < 300 && dones == 0) begin
      @(negedge clk);
      cyc++;
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      if (noise) begin is_store = 1'($urandom); reg_list = 8'($urandom); base_addr = 16'($urandom); end
      mem_ready = $urandom_range(99) < pct;
      #1;
      if ((mem_rd && mem_wr) || (reg_write && !(mem_rd && mem_ready))) bad = 1;
      if (mem_ready && (mem_rd || mem_wr)) begin
        got_q.push_back('{mem_wr, reg_write, mem_wr ? rd_addr : wr_add, mem_addr, mem_wr ? mem_wr_data : wr_data});
        if (mem_wr) mem[mem_addr] = mem_wr_data;
        if (reg_write && wr_add != REG_PC) regs[wr_add] = wr_data;
      end
      if (done) dones++;
    end
    total++; if (dones != 1) $display("FAIL done_seen: got %0d pulses in %0d cycles, required 1", dones, cyc); else passed++;
    if (pct == 100) begin
      total++; if (cyc != exp_q.size() + 1) $display("FAIL latency: got %0d cycles, required %0d", cyc, exp_q.size() + 1); else passed++;
    end
    total++; if (got_q.size() != exp_q.size()) $display("FAIL xfer_count: got %0d, required %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL xfer[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); else passed++;
    end
    total++; if (bad) $display("FAIL strobe_rules: got violation 1, required 0"); else passed++;
    @(negedge clk);
    start = 1'b0;
    #1;
    total++; if ({done, busy} !== 2'b00) $display("FAIL done_width: got done=%b busy=%b, required 0 0", done, busy); else passed++;
  endtask
  task automatic test_reset();
    #2;
    total++;
    if ({rd_addr, reg_write, wr_add, wr_data, mem_addr, mem_rd, mem_wr, mem_wr_data, busy, done} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b, required all 0", busy, done, mem_rd, mem_wr);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({reg_write, mem_rd, mem_wr, busy, done, mem_addr} !== '0)
      $display("FAIL idle_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h, required all 0", busy, done, mem_rd, mem_wr, mem_addr);
    else passed++;
  endtask
  task automatic test_lm_basic();
    mem[16'h0040] = 16'hAAAA; mem[16'h0041] = 16'h5555;
    do_op(1'b0, 16'h0040, 8'h05, 100, 0);
    total++; if (regs[0] !== 16'hAAAA) $display("FAIL lm_r0: got %h, required aaaa", regs[0]); else passed++;
    total++; if (regs[2] !== 16'h5555) $display("FAIL lm_r2: got %h, required 5555", regs[2]); else passed++;
  endtask
  task automatic test_sm_wrap();
    regs[0] = 16'h1234; regs[7] = 16'h0020;
    do_op(1'b1, 16'hFFFF, 8'h81, 100, 0);
    total++; if (mem[16'hFFFF] !== 16'h1234) $display("FAIL sm_ffff: got %h, required 1234", mem[16'hFFFF]); else passed++;
    total++; if (mem[16'h0000] !== 16'h0020) $display("FAIL sm_wrap: got %h, required 0020", mem[16'h0000]); else passed++;
  endtask
  task automatic test_stall();
    mem[16'h0100] = 16'hBEEF; regs[1] = 16'h0000;
    @(negedge clk);
    is_store = 1'b0; base_addr = 16'h0100; reg_list = 8'h02; start = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0; mem_ready = 1'b0;
      #1;
      total++;
      if ({mem_rd, mem_wr, mem_addr, reg_write} !== {1'b1, 1'b0, 16'h0100, 1'b0})
        $display("FAIL stall_hold[%0d]: got rd=%b wr=%b addr=%h we=%b, required 1 0 0100 0", c, mem_rd, mem_wr, mem_addr, reg_write);
      else passed++;
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    total++;
    if ({reg_write, wr_add, wr_data} !== {1'b1, 3'd1, 16'hBEEF})
      $display("FAIL stall_write: got we=%b add=%0d data=%h, required 1 1 beef", reg_write, wr_add, wr_data);
    else passed++;
    if (reg_write && wr_add != REG_PC) regs[wr_add] = wr_data;
    @(negedge clk);
    #1;
    total++; if ({done, reg_write, mem_rd} !== 3'b100) $display("FAIL stall_done: got done=%b we=%b rd=%b, required 1 0 0", done, reg_write, mem_rd); else passed++;
    total++; if (regs[1] !== 16'hBEEF) $display("FAIL stall_r1: got %h, required beef", regs[1]); else passed++;
    @(negedge clk);
  endtask
  task automatic test_empty();
    do_op(1'b0, 16'h0200, 8'h80, 100, 0);
    do_op(1'b0, 16'h0300, 8'h00, 100, 0);
    do_op(1'b1, 16'h0400, 8'h00, 100, 0);
  endtask
  task automatic test_async_reset();
    @(negedge clk);
    is_store = 1'b1; base_addr = 16'h0500; reg_list = 8'hFF; start = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    total++; if (mem_wr !== 1'b1) $display("FAIL pre_reset_wr: got %b, required 1", mem_wr); else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_wr, mem_rd, busy, done, mem_addr} !== '0)
      $display("FAIL async_reset: got wr=%b busy=%b done=%b addr=%h, required 0 0 0 0000", mem_wr, busy, done, mem_addr);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b1, 16'h0600, 8'h3C, 100, 0);
  endtask
  task automatic test_start_noise();
    for (int n = 0; n < 4; n++) do_op(1'($urandom), 16'($urandom), 8'($urandom) | 8'h01, 100, 1);
  endtask
  task automatic test_random();
    for (int n = 0; n < 20; n++) do_op(1'($urandom), 16'($urandom), 8'($urandom), $urandom_range(1) ? 100 : 40, 0);
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
    test_reset();
    test_lm_basic();
    test_sm_wrap();
    test_stall();
    test_empty();
    test_async_reset();
    test_start_noise();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
